// File: rtl/pong_match_controller.sv
// pong_match_controller: match sequencing for a two-player pong game.
// Serves the ball after a start press, flags paddle contacts, keeps the score and
// declares the winner.
// Build option: define PONG_AUTO_SERVE_EN to re-serve automatically after a
// non-winning point; by default the controller waits in HOLD for a start press.
//
// state | meaning
// IDLE  | after reset, ball held, waiting for a start press
// SERVE | ball held at serve position for SERVE_WAIT cycles
// PLAY  | ball released, contacts and misses evaluated
// POINT | one cycle, score updated and point pulse high
// HOLD  | ball held, waiting for a start press to serve again
// OVER  | match won, scores frozen until a start press
module pong_match_controller #(
    parameter int WIN_SCORE  = 7,
    parameter int PADDLE_H   = 4,
    parameter int SERVE_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startBtn,
    input  logic [5:0] xPosition,
    input  logic [4:0] yPosition,
    input  logic       isBallMoving,
    input  logic [4:0] leftPaddleY,
    input  logic [4:0] rightPaddleY,
    output logic       ballResetN,
    output logic       isHittingLeft,
    output logic       isHittingRight,
    output logic [3:0] scoreLeft,
    output logic [3:0] scoreRight,
    output logic       pointLeft,
    output logic       pointRight,
    output logic       gameOver
);

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_POINT, S_HOLD, S_OVER
    } state_t;

    localparam logic [5:0] PAD_SPAN   = 6'(PADDLE_H - 1);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_WAIT - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state;
    logic [7:0] serve_cnt;
    logic       start_prev;
    logic       start_edge;
    logic [5:0] y_ext;
    logic [5:0] left_top;
    logic [5:0] left_bot;
    logic [5:0] right_top;
    logic [5:0] right_bot;

    // Paddle extents in 6-bit space so a paddle near the bottom row never aliases upward.
    assign start_edge = startBtn & ~start_prev;
    assign y_ext      = {1'b0, yPosition};
    assign left_top   = {1'b0, leftPaddleY};
    assign left_bot   = left_top + PAD_SPAN;
    assign right_top  = {1'b0, rightPaddleY};
    assign right_bot  = right_top + PAD_SPAN;

    // Contact flags go straight to the ball block; only meaningful while the ball is live.
    always_comb begin
        isHittingLeft  = 1'b0;
        isHittingRight = 1'b0;
        if (state == S_PLAY) begin
            isHittingLeft  = (xPosition == 6'd1) && (y_ext >= left_top) && (y_ext <= left_bot);
            isHittingRight = (xPosition >= 6'd62) && (y_ext >= right_top) && (y_ext <= right_bot);
        end
    end

    // Match sequencer with registered ball reset, scores, point pulses and game-over flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            serve_cnt  <= 8'd0;
            start_prev <= 1'b1;
            ballResetN <= 1'b0;
            scoreLeft  <= 4'd0;
            scoreRight <= 4'd0;
            pointLeft  <= 1'b0;
            pointRight <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            start_prev <= startBtn;
            pointLeft  <= 1'b0;
            pointRight <= 1'b0;
            case (state)
                S_IDLE: begin
                    ballResetN <= 1'b0;
                    if (start_edge) begin
                        state     <= S_SERVE;
                        serve_cnt <= 8'd0;
                    end
                end
                S_SERVE: begin
                    if (serve_cnt == SERVE_LAST) begin
                        state      <= S_PLAY;
                        ballResetN <= 1'b1;
                    end else begin
                        serve_cnt <= serve_cnt + 8'd1;
                    end
                end
                S_PLAY: begin
                    if (isBallMoving && xPosition == 6'd0) begin
                        state      <= S_POINT;
                        ballResetN <= 1'b0;
                        pointRight <= 1'b1;
                        if (scoreRight != 4'hF) scoreRight <= scoreRight + 4'd1;
                    end else if (isBallMoving && xPosition == 6'd63) begin
                        state      <= S_POINT;
                        ballResetN <= 1'b0;
                        pointLeft  <= 1'b1;
                        if (scoreLeft != 4'hF) scoreLeft <= scoreLeft + 4'd1;
                    end
                end
                S_POINT: begin
                    // Only the scorer can have just reached the winning score.
                    if (scoreLeft == WIN || scoreRight == WIN) begin
                        state    <= S_OVER;
                        gameOver <= 1'b1;
                    end else begin
`ifdef PONG_AUTO_SERVE_EN
                        state     <= S_SERVE;
                        serve_cnt <= 8'd0;
`else
                        state <= S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (start_edge) begin
                        state     <= S_SERVE;
                        serve_cnt <= 8'd0;
                    end
                end
                S_OVER: begin
                    if (start_edge) begin
                        state      <= S_SERVE;
                        serve_cnt  <= 8'd0;
                        scoreLeft  <= 4'd0;
                        scoreRight <= 4'd0;
                        gameOver   <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    ballResetN <= 1'b0;
                end
            endcase
        end
    end

endmodule
